// File: rtl/fp_pkg.sv
// Shared definitions for the parametrised floating-point blocks: default format,
// exponent bias, field extraction and the saturation constant.
package fp_pkg;

  localparam int DEF_EXP_W = 4;
  localparam int DEF_MAN_W = 7;

  // Wide carrier so the helpers work for any format up to 64 bits.
  localparam int MAX_W = 64;
  typedef logic [MAX_W-1:0] word_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic fp_sign(input word_t w, input int exp_w, input int man_w);
    return w[exp_w + man_w];
  endfunction

  function automatic word_t fp_exp(input word_t w, input int exp_w, input int man_w);
    return (w >> man_w) & ((word_t'(1) << exp_w) - word_t'(1));
  endfunction

  function automatic word_t fp_frac(input word_t w, input int man_w);
    return w & ((word_t'(1) << man_w) - word_t'(1));
  endfunction

  // {s, all-ones exponent, all-ones fraction}
  function automatic word_t fp_max_finite(input logic s, input int exp_w, input int man_w);
    return (word_t'(s) << (exp_w + man_w)) | ((word_t'(1) << (exp_w + man_w)) - word_t'(1));
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Normalise, round-to-nearest-even, saturate/flush and pack a raw significand
// product. Purely combinational; shared with the adder datapath.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
)(
  input  logic                          sign,
  input  logic                          zero,
  input  logic signed [EXP_W+1:0]       exp_in,
  input  logic [2*MAN_W+1:0]            prod,
  output logic [EXP_W+MAN_W:0]          res,
  output logic                          ovf,
  output logic                          unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EXP_MAX = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_MIN = EW'(1);

  logic                   shift;
  logic [PW-2:0]          norm;
  logic [MAN_W-1:0]       frac;
  logic                   guard;
  logic                   sticky;
  logic                   round_up;
  logic [MAN_W:0]         frac_r;
  logic signed [EW-1:0]   exp_f;

  // NOTE: every always_comb output gets a default first so no path leaves a latch.
  always_comb begin
    shift    = prod[PW-1];
    // Leading one is dropped; norm holds fraction, guard and sticky bits.
    norm     = shift ? prod[PW-2:0] : {prod[PW-3:0], 1'b0};
    frac     = norm[PW-2 -: MAN_W];
    guard    = norm[PW-2-MAN_W];
    sticky   = |norm[PW-3-MAN_W:0];
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
    exp_f    = exp_in + EW'(shift) + EW'(frac_r[MAN_W]);

    res = {sign, {(W-1){1'b0}}};
    ovf = 1'b0;
    unf = 1'b0;
    if (!zero) begin
      if (exp_f > EXP_MAX) begin
        res = W'(fp_max_finite(sign, EXP_W, MAN_W));
        ovf = 1'b1;
      end else if (exp_f < EXP_MIN) begin
        unf = 1'b1;
      end else begin
        res = {sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};
      end
    end
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow control
// and a single global advance enable (stalls hold every stage, bubbles kept).
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in1,
  input  logic [EXP_W+MAN_W:0]   in2,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic                   out_ovf,
  output logic                   out_unf
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 1;
  localparam int PW = 2 * SW;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS = EW'(fp_bias(EXP_W));

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // S1 combinational unpack
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic             sign_ab;
  logic             zero_ab;
  logic [EW-1:0]    exp_sum;

  always_comb begin
    exp_a   = EXP_W'(fp_exp(word_t'(in1), EXP_W, MAN_W));
    exp_b   = EXP_W'(fp_exp(word_t'(in2), EXP_W, MAN_W));
    frac_a  = MAN_W'(fp_frac(word_t'(in1), MAN_W));
    frac_b  = MAN_W'(fp_frac(word_t'(in2), MAN_W));
    sign_ab = fp_sign(word_t'(in1), EXP_W, MAN_W) ^ fp_sign(word_t'(in2), EXP_W, MAN_W);
    // exp==0 covers denormal encodings too: they flush to zero here.
    zero_ab = (exp_a == '0) || (exp_b == '0);
    exp_sum = {2'b00, exp_a} + {2'b00, exp_b} - BIAS;
  end

  // Stage registers
  logic                  s1_valid, s2_valid;
  logic                  s1_sign, s1_zero, s2_sign, s2_zero;
  logic signed [EW-1:0]  s1_exp, s2_exp;
  logic [SW-1:0]         s1_sig_a, s1_sig_b;
  logic [PW-1:0]         s2_prod;

  // S3 combinational round/pack
  logic [W-1:0] rp_res;
  logic         rp_ovf, rp_unf;

  fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
    .sign   (s2_sign),
    .zero   (s2_zero),
    .exp_in (s2_exp),
    .prod   (s2_prod),
    .res    (rp_res),
    .ovf    (rp_ovf),
    .unf    (rp_unf)
  );

  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_ovf   <= 1'b0;
      out_unf   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      out       <= rp_res;
      out_ovf   <= s2_valid & rp_ovf;
      out_unf   <= s2_valid & rp_unf;
    end
  end

  // NOTE: internal datapath registers carry no reset; their contents only matter
  // when the matching valid bit is set, and that bit is reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign  <= sign_ab;
      s1_zero  <= zero_ab;
      s1_exp   <= exp_sum;
      s1_sig_a <= {1'b1, frac_a};
      s1_sig_b <= {1'b1, frac_b};
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_exp   <= s1_exp;
      s2_prod  <= s1_sig_a * s1_sig_b;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Directed-vector bench for fp_mult_pipe at the default 12-bit format: latency,
// rounding, zero/saturate/flush, backpressure and asynchronous reset mid-stream.
module tb_fp_mult_pipe;
  import fp_pkg::*;

  localparam int EXP_W = DEF_EXP_W;
  localparam int MAN_W = DEF_MAN_W;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [W-1:0] in1, in2;
  logic         out_valid, out_ready;
  logic [W-1:0] out;
  logic         out_ovf, out_unf;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         ovf;
    logic         unf;
  } vec_t;

  // Hand-computed products in the default format.
  vec_t vecs [6] = '{
    '{12'h3C0, 12'h3C0, 12'h410, 1'b0, 1'b0},  // 1.5 * 1.5 = 2.25
    '{12'h3C0, 12'hC00, 12'hC40, 1'b0, 1'b0},  // 1.5 * -2 = -3
    '{12'h381, 12'h3C0, 12'h3C2, 1'b0, 1'b0},  // tie rounds to even
    '{12'h000, 12'hC40, 12'h800, 1'b0, 1'b0},  // zero operand, negative sign
    '{12'h7FF, 12'h7FF, 12'h7FF, 1'b1, 1'b0},  // saturate
    '{12'h080, 12'h880, 12'h800, 1'b0, 1'b1}   // flush to -0
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the result edge.
  task automatic run_single(input vec_t v, input string tag);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in1      = v.a;
    in2      = v.b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ":lat1_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ":lat2_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, ":lat3_valid"}, 32'(out_valid), 32'd1);
    check({tag, ":out"},        32'(out),       32'(v.r));
    check({tag, ":ovf"},        32'(out_ovf),   32'(v.ovf));
    check({tag, ":unf"},        32'(out_unf),   32'(v.unf));
  endtask

  initial begin
    int sent, got, stall;
    bit stalled_once;
    logic [W-1:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:in_ready",  32'(in_ready),  32'd1);
    check("reset:out",       32'(out),       32'd0);
    check("reset:flags",     {30'd0, out_ovf, out_unf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed single operations
    for (int i = 0; i < 6; i++) begin
      run_single(vecs[i], $sformatf("vec%0d", i));
      @(posedge clk); #1;
    end

    // Backpressure: five back-to-back ops, stall four cycles on first result
    sent = 0; got = 0; stall = 0; stalled_once = 0; held = '0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      if (out_valid && !stalled_once) begin
        stalled_once = 1;
        stall        = 4;
        held         = out;
      end
      out_ready = (stall == 0);
      in_valid  = (sent < 5);
      if (sent < 5) begin
        in1 = vecs[sent].a;
        in2 = vecs[sent].b;
      end
      @(negedge clk);
      if (stall > 0) begin
        check("bp:in_ready_stall", 32'(in_ready),  32'd0);
        check("bp:out_held",       32'(out),       32'(held));
        check("bp:valid_held",     32'(out_valid), 32'd1);
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        check($sformatf("bp:out%0d", got), 32'(out),     32'(vecs[got].r));
        check($sformatf("bp:ovf%0d", got), 32'(out_ovf), 32'(vecs[got].ovf));
        check($sformatf("bp:unf%0d", got), 32'(out_unf), 32'(vecs[got].unf));
        got++;
      end
      if (stall > 0) stall--;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp:stalled",  32'(stalled_once), 32'd1);
    check("bp:accepted", 32'(sent), 32'd5);
    check("bp:delivered", 32'(got), 32'd5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp:no_dup", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Asynchronous reset with three ops in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in1      = vecs[i].a;
      in2      = vecs[i].b;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("rst:pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:out",       32'(out),       32'd0);
    check("rst:flags",     {30'd0, out_ovf, out_unf}, 32'd0);
    check("rst:in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst:no_stale", 32'(out_valid), 32'd0);
    end
    run_single(vecs[1], "rst:post");
    @(posedge clk); #1;
    check("rst:post_drain", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined floating-point multiplier for the option-pricing datapath, generalising the 12-bit combinational FP12 multiplier. Exponent and mantissa widths are configurable, with defaults giving the 12-bit format. The block adds a 3-stage pipeline, valid/ready flow control with backpressure, round-to-nearest-even, and overflow/underflow flags. It sits between the pricing-engine operand sources and the accumulation stage.

## Interface
- EXP_W, 4, exponent field width (≥3)
- MAN_W, 7, stored fraction width (≥2); word width W = 1+EXP_W+MAN_W (12 by default)
- clk  input  1  clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- in1, in2  input  W each  operands {sign, exp, frac}
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out  output  W  product
- out_ovf  output  1  result saturated (overflow)
- out_unf  output  1  result flushed to zero (underflow)

## Operation
- Format: bias = 2^(EXP_W-1)-1 (7); value = (-1)^s · 1.frac · 2^(exp-bias).
- exp==0 is zero, including denormal encodings (flushed on input). All-ones exp is an ordinary normal. There is no inf or NaN.
- Sign of every result, including zero, is s1^s2.
- Either input zero: result is signed zero, flags 0.
- Significand product: (MAN_W+1)×(MAN_W+1) gives a 2·MAN_W+2-bit unsigned result. Exponent sum e1+e2-bias is computed in EXP_W+2-bit signed arithmetic.
- Normalise: if the product MSB is set, shift right by 1 and increment the exponent.
- Round to nearest, ties to even, using guard bit plus sticky OR of all lower bits. A rounding carry out of the fraction increments the exponent and clears the fraction.
- Final exponent > 2^EXP_W-1: output max finite magnitude {s, all-ones exp, all-ones frac}, out_ovf=1.
- Final exponent < 1: output signed zero, out_unf=1.
- Flags are qualified by out_valid.

## Timing
- Pipeline stages:
  - S1: unpack, zero detect, sign, exponent sum.
  - S2: significand multiply.
  - S3: normalise, round, saturate/flush, pack; drives out registers.
- Latency is 3 cycles from the accepting edge (in_valid & in_ready) to out_valid, with out_ready held high. Throughput is 1 per cycle.
- Global advance enable: adv = !out_valid | out_ready. in_ready = adv, combinational from out_valid/out_ready only.
- When adv=0, all stage registers and valid bits hold. Bubbles are not collapsed.
- When adv=1, each stage valid bit loads the previous stage's valid; S1 valid loads in_valid.
- Data registers may load don't-care values when the corresponding valid is 0.
- out, out_ovf and out_unf stay stable while out_valid=1 and out_ready=0.
- Reset (asynchronous, any time, including mid-stream): all valid bits, out, and flags go to 0. in_ready = 1 after reset. In-flight operations are discarded.
- in_valid asserted while in_ready=0 is ignored. The source must hold its data.

## Structure
- Shared package fp_pkg holds:
  - bias function
  - field-extract helpers
  - the max-finite constant builder
  - default EXP_W/MAN_W
- One sub-module, fp_round_pack: S3 normalise/round/saturate logic, purely combinational, reused later by the adder.
- Top level holds the stage registers and valid/enable chain.

## Test plan
Defaults throughout (EXP_W=4, MAN_W=7).
- Basic: 0x3C0 × 0x3C0 (1.5×1.5) → 0x410 (2.25) three cycles later, flags 0. Then 0x3C0 × 0xC00 → 0xC40 (-3.0).
- Rounding tie-to-even: 0x381 × 0x3C0 → 0x3C2.
- Zero: 0x000 × 0xC40 → 0x800 (-0), flags 0.
- Saturation and flush:
  - 0x7FF × 0x7FF → 0x7FF, out_ovf=1.
  - 0x080 × 0x880 → 0x800, out_unf=1.
- Backpressure:
  - Stimulus: stream 5 back-to-back ops; drop out_ready for 4 cycles once the first result is valid.
  - Required: in_ready=0 during the stall; out held constant; all 5 results delivered in order with none lost or duplicated.
- Reset mid-stream:
  - Stimulus: assert rst asynchronously (between edges) with 3 ops in flight.
  - Required: out_valid=0 immediately. After release, the next op's result appears exactly 3 cycles after acceptance, with no stale results.
